tlb_lookup_arb: RTL
===================

Name: tlb_lookup_arb

Overview:
- Owns the 8-entry data-side TLB array and shares its single lookup path between the instruction-fetch and dcache requesters.
- Arbitrates round-robin, with one lookup accepted per cycle.
- Matches the VPN against all entries and returns PFN, hit and fault status two cycles after grant.
- Entries are loaded by a config write port (boot loader / OS model); a flush clears all valid bits.

Parameters:
- NUM_ENTRIES, 8, TLB entries; index width is log2(NUM_ENTRIES)=3.
- VPN_W, 20, virtual page number width.
- PFN_W, 20, physical frame number width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ic_req  in  1  ifetch lookup request (level, held until ic_gnt)
- ic_vpn  in  VPN_W  ifetch VPN, stable while ic_req
- ic_gnt  out  1  ifetch request accepted this cycle (combinational)
- dc_req  in  1  dcache lookup request
- dc_vpn  in  VPN_W  dcache VPN
- dc_wr  in  1  dcache access is a write
- dc_gnt  out  1  dcache request accepted this cycle (combinational)
- cfg_wr_en  in  1  write one TLB entry
- cfg_idx  in  3  entry index
- cfg_vpn  in  VPN_W  entry VPN
- cfg_pfn  in  PFN_W  entry PFN
- cfg_v  in  1  entry valid
- cfg_p  in  1  entry present
- cfg_rw  in  1  entry writable
- flush  in  1  clear all valid bits
- rsp_valid  out  1  response strobe, one cycle
- rsp_src  out  1  0=ifetch, 1=dcache
- rsp_pfn  out  PFN_W  translated frame (0 on miss)
- rsp_hit  out  1  valid VPN match found
- rsp_pf  out  1  page fault: miss, or hit with P=0
- rsp_prot  out  1  dcache write to hit entry with RW=0 and P=1

Behaviour:
- Reset (rst_n low, async): all entry V/P/RW=0, VPN/PFN=0. All rsp_* outputs 0. Pipeline valids 0. Round-robin pointer last_src=ifetch, so dcache has first priority.
- Stall: grants are 0 in any cycle where cfg_wr_en or flush is high; requesters keep holding req.
- Arbitration, when not stalled:
  - One requester active: it is granted.
  - Both active: the source not equal to last_src is granted.
  - last_src updates at the edge of each grant.
- Stage A (grant edge T): latch vpn, src and wr (wr forced 0 for ifetch); set a_valid.
- Stage B (cycle T+1): compare the latched VPN against all 8 entries; match = V && (vpn==entry VPN). The lowest matching index is selected.
- Response registers load at the T+1 edge, so rsp_valid is high during cycle T+2. Latency from grant = 2 cycles; throughput = 1 per cycle, back-to-back.
- Response values:
  - Miss: hit=0, pf=1, prot=0, pfn=0.
  - Hit with P=0: hit=1, pf=1, prot=0, pfn=entry PFN.
  - Hit with P=1: pf=0; prot=wr&&!RW.
- When rsp_valid=0, all rsp_* fields are 0.
- Config write: updates entry cfg_idx at the clock edge. The stage-B compare uses entry contents at the start of that cycle, so a write in the same cycle as the compare is not seen by it.
- Flush: clears all V at the edge; a lookup in stage B that cycle still uses pre-flush contents. flush and cfg_wr_en in the same cycle: flush wins, and the write is dropped.
- Reset mid-operation: in-flight lookups are discarded and no response is produced.

Optional Feature:
- TLB_MULTIHIT_CHK_EN:
  - Defined: adds output rsp_multihit (1 bit). When more than one valid entry matches, rsp_multihit=1, rsp_pf=1, rsp_hit=0 and rsp_pfn=0.
  - Undefined: no port; the lowest matching index wins silently.

Decomposition:
- Shared package: VPN_W/PFN_W/index-width constants, SRC_IC=0/SRC_DC=1, and entry field layout {V,P,RW,VPN,PFN}.
- One natural sub-module, tlb_entry_cam: 8 parallel VPN equality compares, valid masking, lowest-index priority encoder, any-hit and multi-hit outputs.

Test Plan:
- Reset, then cfg-write idx3 VPN=0x12345 PFN=0x00ABC V=P=RW=1; dc_req VPN=0x12345 wr=1 -> dc_gnt same cycle; 2 cycles later rsp_valid=1, src=1, hit=1, pfn=0x00ABC, pf=0, prot=0.
- ic_req and dc_req held high together for 4 cycles after reset -> grants alternate dc, ic, dc, ic; four consecutive rsp_valid cycles with src 1,0,1,0.
- Entry idx5 VPN=0x00010 P=1 RW=0; dc write lookup -> hit=1, prot=1, pf=0. Same lookup as ifetch -> prot=0.
- Lookup VPN=0xFFFFF with no match -> hit=0, pf=1, pfn=0. Entry with P=0 matched -> hit=1, pf=1.
- cfg_wr_en high while ic_req high -> ic_gnt=0 that cycle, granted the next cycle. flush asserted with cfg_wr_en -> all V=0, write dropped, next lookup misses.
- Idx1 and idx6 both VPN=0x00777 -> macro off: pfn=idx1 PFN. Macro on: rsp_multihit=1, pf=1, hit=0.

Source files
------------

// File: rtl/tlb_lookup_arb_pkg.sv
// rtl/tlb_lookup_arb_pkg.sv - shared widths, source ids and TLB entry layout
package tlb_lookup_arb_pkg;

  localparam int NUM_ENTRIES = 8;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int VPN_W       = 20;
  localparam int PFN_W       = 20;

  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  typedef struct packed {
    logic             v;
    logic             p;
    logic             rw;
    logic [VPN_W-1:0] vpn;
    logic [PFN_W-1:0] pfn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_lookup_arb_if.sv
// rtl/tlb_lookup_arb_if.sv - requester and response bundle of the TLB lookup arbiter
interface tlb_lookup_arb_if;
  import tlb_lookup_arb_pkg::*;

  logic             ic_req;
  logic [VPN_W-1:0] ic_vpn;
  logic             ic_gnt;
  logic             dc_req;
  logic [VPN_W-1:0] dc_vpn;
  logic             dc_wr;
  logic             dc_gnt;
  logic             rsp_valid;
  logic             rsp_src;
  logic [PFN_W-1:0] rsp_pfn;
  logic             rsp_hit;
  logic             rsp_pf;
  logic             rsp_prot;
`ifdef TLB_MULTIHIT_CHK_EN
  logic             rsp_multihit;
`endif

  modport master (
    output ic_req, ic_vpn, dc_req, dc_vpn, dc_wr,
    input  ic_gnt, dc_gnt, rsp_valid, rsp_src, rsp_pfn, rsp_hit, rsp_pf, rsp_prot
`ifdef TLB_MULTIHIT_CHK_EN
    , input rsp_multihit
`endif
  );

  modport slave (
    input  ic_req, ic_vpn, dc_req, dc_vpn, dc_wr,
    output ic_gnt, dc_gnt, rsp_valid, rsp_src, rsp_pfn, rsp_hit, rsp_pf, rsp_prot
`ifdef TLB_MULTIHIT_CHK_EN
    , output rsp_multihit
`endif
  );

endinterface

// File: rtl/tlb_lookup_arb_entry_cam.sv
// rtl/tlb_lookup_arb_entry_cam.sv - parallel VPN compare with lowest-index priority select
// Multi-hit output exists only under TLB_MULTIHIT_CHK_EN.
module tlb_entry_cam
  import tlb_lookup_arb_pkg::*;
(
  input  logic [VPN_W-1:0]       lookup_vpn,
  input  logic [NUM_ENTRIES-1:0] entry_v,
  input  logic [VPN_W-1:0]       entry_vpn [NUM_ENTRIES],
  output logic                   any_hit,
  output logic [IDX_W-1:0]       hit_idx
`ifdef TLB_MULTIHIT_CHK_EN
  , output logic                 multi_hit
`endif
);

  logic [NUM_ENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = entry_v[i] && (entry_vpn[i] == lookup_vpn);
    end
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  assign any_hit = |match;

`ifdef TLB_MULTIHIT_CHK_EN
  assign multi_hit = |(match & (match - NUM_ENTRIES'(1)));
`endif

endmodule

// File: rtl/tlb_lookup_arb.sv
// rtl/tlb_lookup_arb.sv - 8-entry TLB with round-robin ifetch/dcache lookup, 2-cycle response
// Optional multi-hit detection: TLB_MULTIHIT_CHK_EN.
module tlb_lookup_arb
  import tlb_lookup_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  tlb_lookup_arb_if.slave  lk,
  input  logic             cfg_wr_en,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [VPN_W-1:0] cfg_vpn,
  input  logic [PFN_W-1:0] cfg_pfn,
  input  logic             cfg_v,
  input  logic             cfg_p,
  input  logic             cfg_rw,
  input  logic             flush
);

  tlb_entry_t       entries_q [NUM_ENTRIES];
  tlb_entry_t       entries_d [NUM_ENTRIES];
  logic             last_src_q, last_src_d;
  logic             a_valid_q, a_valid_d;
  logic             a_src_q, a_src_d;
  logic             a_wr_q, a_wr_d;
  logic [VPN_W-1:0] a_vpn_q, a_vpn_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_src_q, rsp_src_d;
  logic [PFN_W-1:0] rsp_pfn_q, rsp_pfn_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic             rsp_pf_q, rsp_pf_d;
  logic             rsp_prot_q, rsp_prot_d;
`ifdef TLB_MULTIHIT_CHK_EN
  logic             rsp_mh_q, rsp_mh_d;
  logic             cam_multi;
`endif

  logic             stall, gnt_ic, gnt_dc;
  logic             cam_hit;
  logic [IDX_W-1:0] cam_idx;
  logic [NUM_ENTRIES-1:0] entry_v;
  logic [VPN_W-1:0] entry_vpn [NUM_ENTRIES];

  // Config writes and flushes own the array for the cycle, so lookups wait.
  always_comb begin
    stall      = cfg_wr_en | flush;
    gnt_ic     = !stall && lk.ic_req && (!lk.dc_req || last_src_q == SRC_DC);
    gnt_dc     = !stall && lk.dc_req && (!lk.ic_req || last_src_q == SRC_IC);
    last_src_d = last_src_q;
    if (gnt_dc)      last_src_d = SRC_DC;
    else if (gnt_ic) last_src_d = SRC_IC;
    a_valid_d  = gnt_ic | gnt_dc;
    a_src_d    = gnt_dc ? SRC_DC : SRC_IC;
    a_vpn_d    = gnt_dc ? lk.dc_vpn : lk.ic_vpn;
    a_wr_d     = gnt_dc & lk.dc_wr;
  end

  assign lk.ic_gnt = gnt_ic;
  assign lk.dc_gnt = gnt_dc;

  always_comb begin
    entries_d = entries_q;
    if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_d[i].v = 1'b0;
    end else if (cfg_wr_en) begin
      entries_d[cfg_idx] = '{v: cfg_v, p: cfg_p, rw: cfg_rw, vpn: cfg_vpn, pfn: cfg_pfn};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_v[i]   = entries_q[i].v;
      entry_vpn[i] = entries_q[i].vpn;
    end
  end

  tlb_entry_cam u_cam (
    .lookup_vpn (a_vpn_q),
    .entry_v    (entry_v),
    .entry_vpn  (entry_vpn),
    .any_hit    (cam_hit),
    .hit_idx    (cam_idx)
`ifdef TLB_MULTIHIT_CHK_EN
    , .multi_hit (cam_multi)
`endif
  );

  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_src_d   = 1'b0;
    rsp_pfn_d   = '0;
    rsp_hit_d   = 1'b0;
    rsp_pf_d    = 1'b0;
    rsp_prot_d  = 1'b0;
`ifdef TLB_MULTIHIT_CHK_EN
    rsp_mh_d    = 1'b0;
`endif
    if (a_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_src_d   = a_src_q;
      if (!cam_hit) begin
        rsp_pf_d = 1'b1;
      end
`ifdef TLB_MULTIHIT_CHK_EN
      else if (cam_multi) begin
        rsp_pf_d = 1'b1;
        rsp_mh_d = 1'b1;
      end
`endif
      else begin
        rsp_hit_d = 1'b1;
        rsp_pfn_d = entries_q[cam_idx].pfn;
        if (!entries_q[cam_idx].p) rsp_pf_d = 1'b1;
        else rsp_prot_d = a_wr_q && !entries_q[cam_idx].rw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
      last_src_q  <= SRC_IC;
      a_valid_q   <= 1'b0;
      a_src_q     <= 1'b0;
      a_wr_q      <= 1'b0;
      a_vpn_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_pfn_q   <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_pf_q    <= 1'b0;
      rsp_prot_q  <= 1'b0;
`ifdef TLB_MULTIHIT_CHK_EN
      rsp_mh_q    <= 1'b0;
`endif
    end else begin
      entries_q   <= entries_d;
      last_src_q  <= last_src_d;
      a_valid_q   <= a_valid_d;
      a_src_q     <= a_src_d;
      a_wr_q      <= a_wr_d;
      a_vpn_q     <= a_vpn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_pfn_q   <= rsp_pfn_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_pf_q    <= rsp_pf_d;
      rsp_prot_q  <= rsp_prot_d;
`ifdef TLB_MULTIHIT_CHK_EN
      rsp_mh_q    <= rsp_mh_d;
`endif
    end
  end

  assign lk.rsp_valid = rsp_valid_q;
  assign lk.rsp_src   = rsp_src_q;
  assign lk.rsp_pfn   = rsp_pfn_q;
  assign lk.rsp_hit   = rsp_hit_q;
  assign lk.rsp_pf    = rsp_pf_q;
  assign lk.rsp_prot  = rsp_prot_q;
`ifdef TLB_MULTIHIT_CHK_EN
  assign lk.rsp_multihit = rsp_mh_q;
`endif

endmodule
